// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus size encodings and copy-engine state enum
package bus_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RGAP = 3'd2,
    WR   = 3'd3,
    WGAP = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/bus_copy_dma.sv
// rtl/bus_copy_dma.sv - word-copy bus master with per-access watchdog
module bus_copy_dma
  import bus_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count,
  output logic             m_valid,
  output logic             m_write,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [1:0]       m_size,
  input  logic             m_ready,
  input  logic [31:0]      m_rdata
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t             state;
  logic [31:0]        src_q;
  logic [31:0]        dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [31:0]        data_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [LEN_W-1:0]   count_inc;
  logic [31:0]        src_next;
  logic               wd_hit;

  assign m_size    = SIZE_W;
  assign count_inc = count + LEN_W'(1);
  assign src_next  = src_q + 32'd4;
  // A zero TIMEOUT means wait forever for the responder.
  assign wd_hit    = (TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      m_valid  <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src & ~32'h3;
            dst_q <= dst & ~32'h3;
            len_q <= len;
            err   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            if (len != '0) begin
              state    <= RD;
              m_valid  <= 1'b1;
              m_write  <= 1'b0;
              m_addr   <= src & ~32'h3;
              wait_cnt <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD, WR: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= (state == RD) ? RGAP : WGAP;
            if (state == RD) data_q <= m_rdata;
          end else if (wd_hit) begin
            m_valid <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RGAP: begin
          state    <= WR;
          m_valid  <= 1'b1;
          m_write  <= 1'b1;
          m_addr   <= dst_q;
          m_wdata  <= data_q;
          wait_cnt <= '0;
        end
        WGAP: begin
          count <= count_inc;
          src_q <= src_next;
          dst_q <= dst_q + 32'd4;
          if (count_inc < len_q) begin
            state    <= RD;
            m_valid  <= 1'b1;
            m_write  <= 1'b0;
            m_addr   <= src_next;
            wait_cnt <= '0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
